cm82_serial_sched: RTL and testbench

- Bit-serial sequencer and arbiter for the shared one-bit full-adder slice (sum = a^b^c, carry = majority).
- Accepts add requests from NREQ requesters with round-robin arbitration.
- Steps the granted operands through the slice LSB-first, one bit per cycle, keeping the carry in a register.
- Returns the WIDTH-bit sum and carry-out to the winner over a valid/ready response channel.

---
 rtl/cm82_serial_sched.sv | 150 +++++++++++++++
 tb/tb_cm82_serial_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cm82_serial_sched.sv
// cm82_serial_sched
//   Round-robin arbiter plus bit-serial sequencer for a shared external
//   one-bit full-adder slice. A granted request is stepped through the
//   slice LSB-first, one bit per cycle, with the running carry held in
//   carry_reg. The WIDTH-bit sum and carry-out are then offered on a
//   valid/ready response channel.
//
// Ports
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   req_valid/ready   per-requester handshake; ready is one-hot or zero
//   req_a/req_b       operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin           per-requester carry-in
//   fa_a/fa_b/fa_c    slice inputs, driven only in RUN (0 otherwise)
//   fa_sum/fa_cout    slice outputs, combinational from fa_* in-cycle
//   rsp_*             result channel: id, sum mod 2^WIDTH, carry-out
//   busy              high whenever an operation is in RUN or DONE
module cm82_serial_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2,
  parameter int ID_W  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  fa_a,
  output logic                  fa_b,
  output logic                  fa_c,
  input  logic                  fa_sum,
  input  logic                  fa_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry_reg;
  logic [ID_W-1:0]  rr_ptr, grant_id;

  // per-requester operand lanes
  logic [NREQ-1:0][WIDTH-1:0] a_lane, b_lane;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*WIDTH +: WIDTH];
    assign b_lane[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Round-robin pick: first valid requester strictly after rr_ptr, wrapping.
  logic [NREQ-1:0] pick;
  logic [ID_W-1:0] win;
  logic            any;
  int              idx;

  always_comb begin
    pick = '0;
    win  = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any       = 1'b1;
        pick[idx] = 1'b1;
        win       = ID_W'(idx);
      end
    end
  end

  // req_ready is held low while reset is asserted so every output reads 0.
  logic accept;
  assign accept = (state == IDLE) && rst_n && any;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_sum   = '0;
    rsp_cout  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (rst_n) req_ready = pick;
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        fa_a = a_reg[cnt];
        fa_b = b_reg[cnt];
        fa_c = carry_reg;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = grant_id;
        rsp_sum   = sum_reg;
        rsp_cout  = carry_reg;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      grant_id  <= '0;
      rr_ptr    <= ID_W'(NREQ - 1);
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          a_reg     <= a_lane[win];
          b_reg     <= b_lane[win];
          carry_reg <= req_cin[win];
          grant_id  <= win;
          cnt       <= '0;
        end
        RUN: begin
          sum_reg[cnt] <= fa_sum;
          carry_reg    <= fa_cout;
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        DONE: if (rsp_ready) rr_ptr <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cm82_serial_sched.sv
// Directed + randomized bench for cm82_serial_sched. The full-adder slice
// is modelled here; expected results come from plain integer addition and
// a round-robin pointer kept by the bench.
module tb_cm82_serial_sched;
  localparam int W  = 8;
  localparam int N  = 2;
  localparam int IW = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_ready, req_cin;
  logic [N*W-1:0] req_a, req_b;
  logic           fa_a, fa_b, fa_c, fa_sum, fa_cout;
  logic           rsp_valid, rsp_ready, rsp_cout, busy;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;

  cm82_serial_sched #(.WIDTH(W), .NREQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_cout(fa_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .busy(busy)
  );

  assign fa_sum  = fa_a ^ fa_b ^ fa_c;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rr;        // model round-robin pointer
  int last_acc;  // edge_cnt seen just after the previous accept

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_cin[r]      = c;
  endtask

  function automatic int winner();
    for (int k = 1; k <= N; k++)
      if (req_valid[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Serve one operation from the current IDLE cycle through the response
  // handshake. hold>0 keeps rsp_ready low for hold DONE cycles.
  // spacing>0 checks the edge distance from the previous accept.
  task automatic serve(input int hold, input int spacing);
    int           w;
    logic [N-1:0] er;
    logic [W-1:0] ea, eb;
    logic         ec;
    logic [W:0]   tot;
    #1;
    w = winner();
    if (w < 0) begin
      chk("winner_exists", 64'd0, 64'd1);
      return;
    end
    er = '0;
    er[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    ea  = req_a[w*W +: W];
    eb  = req_b[w*W +: W];
    ec  = req_cin[w];
    tot = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    rsp_ready = (hold == 0);
    @(posedge clk); #2;
    if (spacing > 0) chk("accept_spacing", 64'(edge_cnt - last_acc), 64'(spacing));
    last_acc = edge_cnt;
    // operands changed after the accept edge must not matter
    set_req(w, W'($urandom), W'($urandom), 1'($urandom));
    for (int i = 0; i < W; i++) begin
      chk("fa_a", 64'(fa_a), 64'(ea[i]));
      chk("fa_b", 64'(fa_b), 64'(eb[i]));
      chk("fa_c", 64'(fa_c), 64'(tot[i] ^ ea[i] ^ eb[i]));
      chk("run_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #2;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_sum", 64'(rsp_sum), 64'(tot[W-1:0]));
    chk("rsp_cout", 64'(rsp_cout), 64'(tot[W]));
    chk("rsp_id", 64'(rsp_id), 64'(w));
    chk("done_fa_a", 64'(fa_a), 64'd0);
    for (int h = 1; h < hold; h++) begin
      @(posedge clk); #2;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_sum", 64'(rsp_sum), 64'(tot[W-1:0]));
      chk("hold_cout", 64'(rsp_cout), 64'(tot[W]));
      chk("hold_id", 64'(rsp_id), 64'(w));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    rr = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_a = '0; req_b = '0; req_cin = '0;
    rst_n = 1'b0;
    rr = N - 1;
    last_acc = 0;

    // reset with both requesters asking: every output stays 0
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // first op after release: requester 0 wins, 0x5A + 0x3C
    set_req(0, 8'h5A, 8'h3C, 1'b0);
    set_req(1, 8'h11, 8'h22, 1'b1);
    rst_n = 1'b1;
    serve(0, 0);

    // carry corner cases on requester 0 alone
    req_valid = 2'b01;
    set_req(0, 8'hFF, 8'h01, 1'b0); serve(0, W + 2);
    set_req(0, 8'h00, 8'h00, 1'b1); serve(0, W + 2);
    set_req(0, 8'hFF, 8'hFF, 1'b1); serve(0, W + 2);

    // both valid continuously: alternating grants, one accept per W+2 edges
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      set_req(0, W'($urandom), W'($urandom), 1'($urandom));
      set_req(1, W'($urandom), W'($urandom), 1'($urandom));
      serve(0, W + 2);
    end

    // backpressure: five DONE cycles with rsp_ready low
    set_req(0, 8'hC3, 8'h5D, 1'b1);
    serve(5, W + 2);

    // randomized request patterns and response stalls
    for (int k = 0; k < 12; k++) begin
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) set_req(r, W'($urandom), W'($urandom), 1'($urandom));
      serve($urandom_range(0, 3), 0);
    end

    // reset in the middle of RUN: operation abandoned, no response
    req_valid = 2'b01;
    set_req(0, 8'hAA, 8'h55, 1'b1);
    #1;
    chk("mid_req_ready", 64'(req_ready), 64'(winner() == 0 ? 1 : 0));
    @(posedge clk); #2;
    repeat (3) begin
      chk("mid_run_busy", 64'(busy), 64'd1);
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_fa", 64'({fa_a, fa_b, fa_c}), 64'd0);
    req_valid = 2'b10;
    set_req(1, 8'h7E, 8'h81, 1'b1);
    @(posedge clk); #2;
    chk("mid_rst_rsp_valid2", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    rr = N - 1;
    serve(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
